// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arbiter_pkg;

    localparam int ALU_W = 16;
    localparam int OPC_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arbiter_picker.sv
// Combinational grant picker. Round-robin from ptr by default; with
// ALU_ARBITER_FIXED_PRIO_EN defined the lowest valid index always wins.
module alu_arbiter_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest-index valid requester wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req_valid[i]) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end
`else
    int idx;

    // First valid requester scanning ptr, ptr+1, ... with wrap
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req_valid[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/behavioral_ALU.sv
// Shared combinational ALU used behind the arbiter.
// Opcodes: 0 add-with-carry, 1 subtract-with-borrow, 2 and, 3 or, 4 xor,
// 5 not A, 6 shift-left through carry, 7 shift-right through carry.
module behavioral_ALU
    import alu_arbiter_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             C,
    input  logic [OPC_W-1:0] opcode,
    output logic [W-1:0]     outW,
    output logic             zer,
    output logic             neg
);

    logic [W-1:0] cin;
    assign cin = {{(W-1){1'b0}}, C};

    // Result mux; flags derive from the selected result
    always_comb begin
        outW = '0;
        case (opcode)
            3'd0:    outW = A + B + cin;
            3'd1:    outW = A - B - cin;
            3'd2:    outW = A & B;
            3'd3:    outW = A | B;
            3'd4:    outW = A ^ B;
            3'd5:    outW = ~A;
            3'd6:    outW = {A[W-2:0], C};
            3'd7:    outW = {C, A[W-1:1]};
            default: outW = '0;
        endcase
    end

    assign zer = (outW == '0);
    assign neg = outW[W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one behavioral_ALU between NREQ requesters: accept, execute for
// one cycle, hold the result until the consumer takes it.
// Optional macro ALU_ARBITER_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ALU_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    input  logic [NREQ-1:0]           req_c,
    input  logic [NREQ*OPC_W-1:0]     req_opc,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [W-1:0]              rsp_w,
    output logic                      rsp_zer,
    output logic                      rsp_neg,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             any;

    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             op_c;
    logic [OPC_W-1:0] op_opc;
    logic [IDW-1:0]   op_id;

    logic [W-1:0]     alu_w;
    logic             alu_zer;
    logic             alu_neg;

    logic [W-1:0]     a_arr   [NREQ];
    logic [W-1:0]     b_arr   [NREQ];
    logic [OPC_W-1:0] opc_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]   = req_a[i*W +: W];
        assign b_arr[i]   = req_b[i*W +: W];
        assign opc_arr[i] = req_opc[i*OPC_W +: OPC_W];
    end

    alu_arbiter_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .any       (any)
    );

    // Accept strobe only while idle; rsp_ready has no path here
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;

    behavioral_ALU #(
        .W (W)
    ) u_alu (
        .A      (op_a),
        .B      (op_b),
        .C      (op_c),
        .opcode (op_opc),
        .outW   (alu_w),
        .zer    (alu_zer),
        .neg    (alu_neg)
    );

    // Control FSM with operand and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_w     <= '0;
            rsp_zer   <= 1'b0;
            rsp_neg   <= 1'b0;
            rsp_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= 1'b0;
            op_opc    <= '0;
            op_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        op_a   <= a_arr[gnt_idx];
                        op_b   <= b_arr[gnt_idx];
                        op_c   <= req_c[gnt_idx];
                        op_opc <= opc_arr[gnt_idx];
                        op_id  <= gnt_idx;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_w     <= alu_w;
                    rsp_zer   <= alu_zer;
                    rsp_neg   <= alu_neg;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
                        ptr       <= (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grant monitor predicts accepts and
// queues expected results; response monitor pops and compares.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_c;
    logic [11:0] req_opc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_w;
    logic        rsp_zer;
    logic        rsp_neg;
    logic        busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_opc   (req_opc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_w     (rsp_w),
        .rsp_zer   (rsp_zer),
        .rsp_neg   (rsp_neg),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [15:0] w;
        logic        zer;
        logic        neg;
        int          acc;
        bit          shown;
    } exp_t;

    exp_t       q[$];
    int         m_ptr   = 0;
    int         cyc_n   = 0;
    int         checks  = 0;
    int         errors  = 0;
    bit         prev_rst = 1'b0;
    logic [3:0] keep    = 4'b0;
    bit         rand_mode = 1'b0;
    bit         sweep   = 1'b0;
    int         opc_ctr = 0;
    logic [3:0] last_g  = 4'b0;

    // Reference ALU from its arithmetic definition
    function automatic logic [15:0] ref_alu(logic [15:0] a, logic [15:0] b, logic c, logic [2:0] opc);
        int s;
        case (opc)
            3'd0: s = int'(a) + int'(b) + int'(c);
            3'd1: s = int'(a) - int'(b) - int'(c);
            3'd2: s = int'(a & b);
            3'd3: s = int'(a | b);
            3'd4: s = int'(a ^ b);
            3'd5: s = 65535 - int'(a);
            3'd6: s = int'(a) * 2 + int'(c);
            default: s = int'(a) / 2 + int'(c) * 32768;
        endcase
        return s[15:0];
    endfunction

    // Which requester should win given valids and the priority pointer
    function automatic int pick(logic [3:0] v, int p);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    // Grant monitor: expected req_ready/busy, pushes expected result on accept
    always @(negedge clk) begin
        int          g;
        logic [3:0]  exp_rdy;
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        cyc_n++;
        g = (rst || q.size() != 0) ? -1 : pick(req_valid, m_ptr);
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready cyc %0d: got %b want %b", cyc_n, req_ready, exp_rdy);
        end
        checks++;
        if (busy !== (q.size() != 0)) begin
            errors++;
            $display("FAIL busy cyc %0d: got %b want %b", cyc_n, busy, (q.size() != 0));
        end
        if (g >= 0) begin
            a       = req_a[g*16 +: 16];
            b       = req_b[g*16 +: 16];
            e.id    = g;
            e.w     = ref_alu(a, b, req_c[g], req_opc[g*3 +: 3]);
            e.zer   = (e.w == 16'd0);
            e.neg   = e.w[15];
            e.acc   = cyc_n;
            e.shown = 1'b0;
            q.push_back(e);
        end
    end

    // Response monitor: compares held result, latency, and reset clearing
    always @(negedge clk) begin
        #1;
        if (prev_rst) begin
            checks++;
            if ({rsp_valid, rsp_zer, rsp_neg, busy, rsp_id, rsp_w} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got v=%b id=%0d w=%h z=%b n=%b busy=%b want all 0",
                         cyc_n, rsp_valid, rsp_id, rsp_w, rsp_zer, rsp_neg, busy);
            end
        end
        if (rsp_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc %0d: got id=%0d w=%h want no response", cyc_n, rsp_id, rsp_w);
            end else begin
                if (rsp_id !== 2'(q[0].id) || rsp_w !== q[0].w || rsp_zer !== q[0].zer || rsp_neg !== q[0].neg) begin
                    errors++;
                    $display("FAIL rsp_data cyc %0d: got id=%0d w=%h z=%b n=%b want id=%0d w=%h z=%b n=%b",
                             cyc_n, rsp_id, rsp_w, rsp_zer, rsp_neg, q[0].id, q[0].w, q[0].zer, q[0].neg);
                end
                if (!q[0].shown) begin
                    checks++;
                    if (cyc_n != q[0].acc + 2) begin
                        errors++;
                        $display("FAIL rsp_latency: got cyc %0d want cyc %0d", cyc_n, q[0].acc + 2);
                    end
                    q[0].shown = 1'b1;
                end
                if (rsp_ready && !rst) begin
                    m_ptr = (q[0].id + 1) % 4;
                    void'(q.pop_front());
                end
            end
        end else if (q.size() != 0 && !rst && (q[0].shown || cyc_n == q[0].acc + 2)) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing cyc %0d: got rsp_valid 0 want 1 (id=%0d)", cyc_n, q[0].id);
        end
        if (rst) begin
            q.delete();
            m_ptr = 0;
        end
        prev_rst = rst;
    end

    task automatic refill(input int i);
        req_valid[i]       = 1'b1;
        req_a[i*16 +: 16]  = 16'($urandom);
        req_b[i*16 +: 16]  = 16'($urandom);
        req_c[i]           = 1'($urandom);
        req_opc[i*3 +: 3]  = sweep ? 3'(opc_ctr) : 3'($urandom);
        if (sweep) opc_ctr++;
    endtask

    // One clock: observe accepts, then update requesters after the edge
    task automatic cyc();
        @(negedge clk);
        last_g = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (last_g[i]) begin
                if (keep[i] || (rand_mode && $urandom_range(0, 1) == 1)) refill(i);
                else req_valid[i] = 1'b0;
            end else if (rand_mode && req_valid[i] && $urandom_range(0, 15) == 0) begin
                req_valid[i] = 1'b0;
            end else if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                refill(i);
            end
        end
        if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (req_valid == 4'b0 && q.size() == 0) return;
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: got still busy after 300 cycles want idle");
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 50; n++) begin
            if (rsp_valid) return;
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL wait_rsp: got no rsp_valid in 50 cycles want response");
    endtask

    task automatic wait_grant(input int i);
        for (int n = 0; n < 50; n++) begin
            cyc();
            if (last_g[i]) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_grant %0d: got no grant in 50 cycles want grant", i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        req_opc   = '0;

        // Reset with all requesters valid, then fairness with opcode sweep
        sweep = 1'b1;
        keep  = 4'b1111;
        for (int i = 0; i < 4; i++) refill(i);
        cyc();
        cyc();
        rst = 1'b0;
        repeat (40) cyc();
        sweep = 1'b0;
        keep  = 4'b0;
        wait_idle();

        // Single request from requester 2 with fixed operands
        req_valid[2]     = 1'b1;
        req_a[32 +: 16]  = 16'h1234;
        req_b[32 +: 16]  = 16'h00FF;
        req_c[2]         = 1'b1;
        req_opc[6 +: 3]  = 3'd0;
        wait_rsp();
        checks++;
        if (rsp_w !== 16'h1334 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_req: got id=%0d w=%h want id=2 w=1334", rsp_id, rsp_w);
        end
        wait_idle();

        // Backpressure: result held 10 cycles while 1 and 3 wait
        rsp_ready = 1'b0;
        keep      = 4'b1010;
        refill(1);
        refill(3);
        wait_rsp();
        repeat (10) cyc();
        rsp_ready = 1'b1;
        keep      = 4'b0;
        wait_idle();

        // Wrap-around: serve 2, then 0 and 3 pending together
        refill(2);
        wait_idle();
        refill(0);
        refill(3);
        wait_idle();

        // Reset while the accepted request is executing
        refill(1);
        wait_grant(1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        refill(2);
        refill(3);
        wait_idle();

        // Randomised traffic with drops and random backpressure
        rand_mode = 1'b1;
        repeat (400) cyc();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        keep      = 4'b0;
        wait_idle();
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `behavioral_ALU` between `NREQ` requesters.
- Round-robin arbitration; each requester uses a valid/ready handshake.
- Operands are registered, the shared ALU evaluates them for one cycle, and the result is held in a response register until the single consumer accepts it.
- The block sits between the requesting units and the ALU. It is the only path by which any unit reaches the ALU.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 16: operand/result width; must match the ALU.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `req_a`  in  NREQ*W  packed A operands; slice i belongs to requester i.
- `req_b`  in  NREQ*W  packed B operands.
- `req_c`  in  NREQ  carry-in bits.
- `req_opc`  in  NREQ*3  opcodes; passed to the ALU unchanged.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the result.
- `rsp_w`  out  W  ALU `outW`.
- `rsp_zer`  out  1  ALU `zer`.
- `rsp_neg`  out  1  ALU `neg`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, the picker selects grant `g`, and `req_ready[g]`=1 combinationally in the same cycle.
  - On the clock edge the block latches `req_a[g]`, `req_b[g]`, `req_c[g]`, `req_opc[g]` and `g`, then moves to EXEC.
  - If no `req_valid` is high, it stays in IDLE and all `req_ready` are 0.
- **EXEC**
  - The ALU is driven only from the latched operand registers.
  - On the edge, `outW`/`zer`/`neg` are captured into `rsp_w`/`rsp_zer`/`rsp_neg`, `rsp_id` is set to `g`, and the state moves to RESP.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_w`, `rsp_zer`, `rsp_neg` and `rsp_id` are stable until accepted.
  - On an edge with `rsp_ready`=1, the block returns to IDLE and sets the priority pointer `ptr` to (g+1) mod NREQ.
- **Round-robin rule:** the grant is the first set `req_valid` bit scanning `ptr`, ptr+1, … with wrap at NREQ-1 → 0.
- **Requester contract:** once `req_valid` is asserted, the requester holds it and its operands until it sees `req_ready`. The arbiter never grants a requester whose `req_valid` is low.
- **Dropped requests:** a requester that deasserts `req_valid` before being granted is skipped without error.
- **Simultaneous requests:** only one `req_ready` bit is ever high. Losers are re-arbitrated on the next IDLE visit.
- **Non-blocking RESP:** new `req_valid` assertions during EXEC/RESP are not accepted (`req_ready`=0) and do not disturb the held result.
- **Reset mid-operation:** any in-flight or held result is discarded and never reported. The state returns to IDLE and `ptr` goes to 0.

## Timing
- Reset values (applied at the first edge with `rst` high):
  - state IDLE, `ptr`=0;
  - `rsp_valid`=0, `rsp_w`=0, `rsp_zer`=0, `rsp_neg`=0, `rsp_id`=0, `busy`=0.
- `req_ready` is forced to 0 while `rst`=1.
- Accept in cycle k → `rsp_valid` rises in cycle k+2.
- Minimum request-to-request spacing is 3 cycles when `rsp_ready` is tied high. Throughput is 1 operation per 3 cycles.
- **Backpressure:** with `rsp_ready` held low, the block stays in RESP indefinitely and all `req_ready` remain 0.
- **Combinational paths:** `req_ready` depends only on the state, `ptr` and `req_valid`. No path exists from `rsp_ready` to `req_ready`.

## Configuration
- Macro: `ALU_ARBITER_FIXED_PRIO_EN`.
- **Defined:** fixed priority. The lowest-index valid requester always wins, and `ptr` is neither used nor updated.
- **Undefined (default):** round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_arbiter_pkg` holds:
  - the `state_t` enum (IDLE, EXEC, RESP);
  - the constants `ALU_W`=16 and `OPC_W`=3.
- Sub-module `alu_arbiter_picker`: purely combinational. It takes `req_valid` and `ptr` and produces one-hot `gnt` and encoded `gnt_idx`. The `ALU_ARBITER_FIXED_PRIO_EN` selection lives here.
- The top level holds:
  - the FSM;
  - the operand and response registers;
  - one `behavioral_ALU` instance.

## Test plan
- **Reset:** hold `rst` 2 cycles with `req_valid`=4'b1111.
  - During reset: all outputs are 0 and `req_ready`=0.
  - After release: `req_ready`=4'b0001 in the first cycle.
- **Single request:** requester 2 sends a=16'h1234, b=16'h00FF, c=1, opc=3'd0, with `rsp_ready`=1.
  - `req_ready[2]` is high in cycle k.
  - In cycle k+2: `rsp_valid`=1, `rsp_id`=2, and `rsp_w`/`rsp_zer`/`rsp_neg` equal a standalone `behavioral_ALU` driven with the same inputs.
- **Fairness:** all 4 requesters hold `req_valid`; sweep `opc` 0..7 with random operands.
  - Grant order is 0, 1, 2, 3, 0, …
  - Every result matches the standalone ALU.
  - Built with `ALU_ARBITER_FIXED_PRIO_EN`, requester 0 is granted every time.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles in RESP while requesters 1 and 3 are valid.
  - `rsp_w` stays stable and `req_ready`=0 throughout.
  - After `rsp_ready`=1, the next grant goes to the first valid index at or after (g+1) mod 4.
- **Wrap-around:** ptr=3 (after serving requester 2) with only requesters 0 and 3 valid.
  - Requester 3 is granted, then requester 0.
- **Reset mid-operation:** assert `rst` during EXEC.
  - `rsp_valid` never rises for that request, and the next accepted grant is computed from ptr=0.
